// File: rtl/kv_pkg.sv
// Shared types and defaults for the K/V cache blocks.
package kv_pkg;
  localparam int SEQ_LEN_DEF = 64;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} scan_state_t;
endpackage

// File: rtl/kv_cache_ctrl_if.sv
// Control bundle between the K/V producer / score engine and kv_cache_ctrl.
interface kv_cache_ctrl_if import kv_pkg::*; #(
  parameter int SEQ_LEN = SEQ_LEN_DEF
);
  localparam int AW = $clog2(SEQ_LEN);

  logic          clear;
  logic          app_valid;
  logic          app_ready;
  logic          cache_write_en;
  logic [AW-1:0] cache_write_addr;
  logic          scan_start;
  logic          scan_busy;
  logic [AW-1:0] cache_read_addr;
  logic          out_valid;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          scan_done;
  logic [AW:0]   count;
  logic          full;

  modport master (
    output clear, app_valid, scan_start,
    input  app_ready, cache_write_en, cache_write_addr, scan_busy,
           cache_read_addr, out_valid, out_idx, out_last, scan_done,
           count, full
  );

  modport slave (
    input  clear, app_valid, scan_start,
    output app_ready, cache_write_en, cache_write_addr, scan_busy,
           cache_read_addr, out_valid, out_idx, out_last, scan_done,
           count, full
  );
endinterface

// File: rtl/kv_cache_ctrl.sv
// K/V cache sequencer: appends rows at the fill pointer and streams
// rows 0..N-1 to the score engine with index/last tags aligned to the
// registered cache read.
module kv_cache_ctrl import kv_pkg::*; #(
  parameter int SEQ_LEN = SEQ_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  kv_cache_ctrl_if.slave  bus
);
  localparam int AW = $clog2(SEQ_LEN);

  scan_state_t   state;
  logic [AW:0]   cnt;
  logic [AW:0]   snap;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          app_ready;
  logic          we;
  logic          last_issue;
  logic          empty_scan;
  logic          ov, ol, sd;
  logic [AW-1:0] oi;

  assign full       = (cnt == (AW+1)'(SEQ_LEN));
  assign app_ready  = !full && !bus.clear;
  assign we         = bus.app_valid && app_ready;
  // Final address of this scan is being issued this cycle.
  assign last_issue = (state == SCAN) && ({1'b0, rd_addr} == snap - 1'b1);
  // Scan request with nothing stored: just acknowledge with scan_done.
  assign empty_scan = (state == IDLE) && bus.scan_start && (cnt == '0);

  assign bus.app_ready        = app_ready;
  assign bus.cache_write_en   = we;
  assign bus.cache_write_addr = cnt[AW-1:0];
  assign bus.scan_busy        = (state != IDLE);
  assign bus.cache_read_addr  = rd_addr;
  assign bus.out_valid        = ov;
  assign bus.out_idx          = oi;
  assign bus.out_last         = ol;
  assign bus.scan_done        = sd;
  assign bus.count            = cnt;
  assign bus.full             = full;

  // Fill count: clear wins, otherwise bump on each accepted append.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (bus.clear) cnt <= '0;
    else if (we)        cnt <= cnt + 1'b1;
  end

  // Scan FSM; N is snapshotted before any same-cycle append lands, so
  // writes always target addresses >= N while reads stay below N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_addr <= '0;
      snap    <= '0;
    end else if (bus.clear) begin
      state   <= IDLE;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (bus.scan_start && cnt != '0) begin
          state   <= SCAN;
          rd_addr <= '0;
          snap    <= cnt;
        end
        SCAN: if (last_issue) state <= DRAIN;
              else            rd_addr <= rd_addr + 1'b1;
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One-stage tag pipeline matching the cache's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov <= 1'b0;
      ol <= 1'b0;
      sd <= 1'b0;
      oi <= '0;
    end else if (bus.clear) begin
      ov <= 1'b0;
      ol <= 1'b0;
      sd <= 1'b0;
    end else begin
      ov <= (state == SCAN);
      oi <= rd_addr;
      ol <= last_issue;
      sd <= last_issue || empty_scan;
    end
  end
endmodule

// File: tb/tb_kv_cache_ctrl.sv
// Directed bench for kv_cache_ctrl (SEQ_LEN = 64).
module tb_kv_cache_ctrl;
  import kv_pkg::*;
  localparam int SEQ_LEN = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   beats;

  always #5 clk = ~clk;

  kv_cache_ctrl_if #(.SEQ_LEN(SEQ_LEN)) bus();
  kv_cache_ctrl #(.SEQ_LEN(SEQ_LEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic append(input int k);
    repeat (k) begin
      bus.app_valid = 1'b1;
      step();
    end
    bus.app_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.clear      = 1'b0;
    bus.app_valid  = 1'b0;
    bus.scan_start = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    // Reset state
    chk("rst_count",    32'(bus.count), 0);
    chk("rst_busy",     32'(bus.scan_busy), 0);
    chk("rst_raddr",    32'(bus.cache_read_addr), 0);
    chk("rst_ovalid",   32'(bus.out_valid), 0);
    chk("rst_olast",    32'(bus.out_last), 0);
    chk("rst_done",     32'(bus.scan_done), 0);
    chk("rst_oidx",     32'(bus.out_idx), 0);
    chk("rst_we",       32'(bus.cache_write_en), 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(bus.app_ready), 1);

    // Fill to SEQ_LEN; the extra request must not write
    for (int i = 0; i < SEQ_LEN; i++) begin
      bus.app_valid = 1'b1;
      settle();
      chk("fill_we",    32'(bus.cache_write_en), 1);
      chk("fill_waddr", 32'(bus.cache_write_addr), 32'(i));
      step();
    end
    settle();
    chk("full_count", 32'(bus.count), 64);
    chk("full_flag",  32'(bus.full), 1);
    chk("full_ready", 32'(bus.app_ready), 0);
    chk("full_we",    32'(bus.cache_write_en), 0);
    step();
    chk("full_hold",  32'(bus.count), 64);
    bus.app_valid = 1'b0;

    // Clear empties the cache and blocks appends that cycle
    bus.clear = 1'b1;
    settle();
    chk("clr_ready", 32'(bus.app_ready), 0);
    step();
    bus.clear = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_full",  32'(bus.full), 0);

    // Scan after 5 appends
    append(5);
    chk("s5_count", 32'(bus.count), 5);
    bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      chk("s5_busy",  32'(bus.scan_busy), (k <= 6) ? 1 : 0);
      chk("s5_raddr", 32'(bus.cache_read_addr), (k <= 5) ? 32'(k - 1) : 4);
      chk("s5_ovld",  32'(bus.out_valid), (k >= 2 && k <= 6) ? 1 : 0);
      if (k >= 2 && k <= 6) chk("s5_oidx", 32'(bus.out_idx), 32'(k - 2));
      chk("s5_olast", 32'(bus.out_last), (k == 6) ? 1 : 0);
      chk("s5_done",  32'(bus.scan_done), (k == 6) ? 1 : 0);
      step();
    end

    // Empty scan: immediate scan_done, no busy, no beats
    pulse_clear();
    bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    chk("e_done", 32'(bus.scan_done), 1);
    chk("e_busy", 32'(bus.scan_busy), 0);
    chk("e_ovld", 32'(bus.out_valid), 0);
    step();
    chk("e_done2", 32'(bus.scan_done), 0);
    chk("e_busy2", 32'(bus.scan_busy), 0);

    // Append concurrent with scan start and during the scan
    append(3);
    bus.scan_start = 1'b1;
    bus.app_valid  = 1'b1;
    settle();
    chk("c_waddr0", 32'(bus.cache_write_addr), 3);
    chk("c_we0",    32'(bus.cache_write_en), 1);
    step();
    bus.scan_start = 1'b0;
    beats = 0;
    for (int k = 1; k <= 6; k++) begin
      bus.app_valid = (k <= 2);
      settle();
      if (bus.out_valid) beats++;
      if (k <= 2) begin
        chk("c_waddr",   32'(bus.cache_write_addr), 32'(3 + k));
        chk("c_nocoll",  32'(bus.cache_write_addr != bus.cache_read_addr), 1);
      end
      chk("c_olast", 32'(bus.out_last), (k == 4) ? 1 : 0);
      step();
    end
    bus.app_valid = 1'b0;
    chk("c_beats", 32'(beats), 3);
    chk("c_count", 32'(bus.count), 6);

    // Clear on the third beat of an 8-row scan
    pulse_clear();
    append(8);
    bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    step();
    step();
    step();
    chk("cm_ovld", 32'(bus.out_valid), 1);
    chk("cm_oidx", 32'(bus.out_idx), 2);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("cm_count", 32'(bus.count), 0);
    chk("cm_raddr", 32'(bus.cache_read_addr), 0);
    chk("cm_busy",  32'(bus.scan_busy), 0);
    for (int k = 0; k < 10; k++) begin
      chk("cm_ovld_after", 32'(bus.out_valid), 0);
      chk("cm_done_after", 32'(bus.scan_done), 0);
      step();
    end
    bus.app_valid = 1'b1;
    settle();
    chk("cm_waddr", 32'(bus.cache_write_addr), 0);
    chk("cm_we",    32'(bus.cache_write_en), 1);
    step();
    bus.app_valid = 1'b0;

    // Asynchronous reset in the middle of a scan
    append(3);
    bus.scan_start = 1'b1;
    step();
    bus.scan_start = 1'b0;
    step();
    chk("ar_ovld_pre", 32'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ovld",  32'(bus.out_valid), 0);
    chk("ar_busy",  32'(bus.scan_busy), 0);
    chk("ar_count", 32'(bus.count), 0);
    chk("ar_raddr", 32'(bus.cache_read_addr), 0);
    chk("ar_oidx",  32'(bus.out_idx), 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("ar_ready",  32'(bus.app_ready), 1);
    chk("ar_count2", 32'(bus.count), 0);
    chk("ar_busy2",  32'(bus.scan_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
